calc_keypad_scan: RTL and testbench

Front-end controller for the calculator arithmetic unit. It scans a 4x4 active-low matrix keypad, synchronizes and debounces the row lines, and encodes each accepted press into a 4-bit key code with a one-cycle valid strobe. It drives the arithmetic unit's `data_in` and `flag` inputs directly, so that unit sees exactly one event per physical keystroke.

---
 rtl/calc_keypad_scan.sv | 207 ++++++++++++++++++++
 tb/tb_calc_keypad_scan.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_keypad_scan.sv
// -----------------------------------------------------------------------------
// calc_keypad_scan
//
// Scans a 4x4 active-low matrix keypad and turns each debounced keystroke into
// a single event for the calculator arithmetic unit.
//
// The column drive rotates one column per SCAN_DIV clocks. When the last clock
// of a slot sees exactly one row low, that key is latched and the column is
// frozen. The row pattern must then stay unchanged for DEBOUNCE_CNT clocks. A
// one-cycle strobe follows, and all rows must stay high for DEBOUNCE_CNT clocks
// before scanning resumes. A held key therefore produces exactly one strobe.
//
// Parameters
//   SCAN_DIV      clocks per column slot (>= 4)
//   DEBOUNCE_CNT  consecutive stable clocks needed on press and on release (>= 2)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row[3:0]   keypad row lines, pulled up; low = key closed in driven column
//   col[3:0]   column drive, one-hot active-low
//   key_code   {row_index, col_index} of the last accepted key (to data_in)
//   key_valid  one-cycle strobe when key_code is new (to flag)
//   key_held   high from debounce start until release is confirmed
// -----------------------------------------------------------------------------
module calc_keypad_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DBC_W  = $clog2(DEBOUNCE_CNT);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DBC_W-1:0]  DBC_LAST  = DBC_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_RELEASE
  } state_t;

  // Synchronizer and registered state
  logic [3:0]        row_meta;
  logic [3:0]        rs;
  state_t            state,       state_nxt;
  logic [SCAN_W-1:0] scan_cnt,    scan_cnt_nxt;
  logic [DBC_W-1:0]  dbc,         dbc_nxt;
  logic [1:0]        col_idx,     col_idx_nxt;
  logic [1:0]        row_idx,     row_idx_nxt;
  logic [3:0]        row_pat,     row_pat_nxt;
  logic [3:0]        key_code_q,  key_code_nxt;

  // Row decode of the synchronized lines
  logic [3:0] rs_low;
  logic       one_low;
  logic [1:0] row_enc;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer on the asynchronous row lines. Idle keypad reads as
  // all-high, so that is the reset value.
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use <= so every flop samples pre-edge values; blocking
  // assignments here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      rs       <= 4'b1111;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Exactly-one-low detection. Two or more low rows in one column means a
  // multi-press or ghost, which is ignored.
  // ---------------------------------------------------------------------------
  assign rs_low  = ~rs;
  assign one_low = (rs_low != 4'd0) && ((rs_low & (rs_low - 4'd1)) == 4'd0);

  always_comb begin
    row_enc = 2'd0;
    case (rs_low)
      4'b0001: row_enc = 2'd0;
      4'b0010: row_enc = 2'd1;
      4'b0100: row_enc = 2'd2;
      4'b1000: row_enc = 2'd3;
      default: row_enc = 2'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SCAN;
      scan_cnt   <= '0;
      dbc        <= '0;
      col_idx    <= 2'd0;
      row_idx    <= 2'd0;
      row_pat    <= 4'b1111;
      key_code_q <= 4'd0;
    end else begin
      state      <= state_nxt;
      scan_cnt   <= scan_cnt_nxt;
      dbc        <= dbc_nxt;
      col_idx    <= col_idx_nxt;
      row_idx    <= row_idx_nxt;
      row_pat    <= row_pat_nxt;
      key_code_q <= key_code_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets its hold value first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_nxt    = state;
    scan_cnt_nxt = scan_cnt;
    dbc_nxt      = dbc;
    col_idx_nxt  = col_idx;
    row_idx_nxt  = row_idx;
    row_pat_nxt  = row_pat;
    key_code_nxt = key_code_q;

    case (state)
      ST_SCAN: begin
        // Sampling only in the last slot cycle hides the two-cycle
        // synchronizer delay after a column change.
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_nxt = '0;
          if (one_low) begin
            row_idx_nxt = row_enc;
            row_pat_nxt = rs;
            dbc_nxt     = '0;
            state_nxt   = ST_DEBOUNCE;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end else begin
          scan_cnt_nxt = scan_cnt + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (rs != row_pat) begin
          state_nxt    = ST_SCAN;
          col_idx_nxt  = col_idx + 2'd1;
          scan_cnt_nxt = '0;
          dbc_nxt      = '0;
        end else if (dbc == DBC_LAST) begin
          // key_code is loaded on entry so it is already new during EMIT.
          state_nxt    = ST_EMIT;
          key_code_nxt = {row_idx, col_idx};
          dbc_nxt      = '0;
        end else begin
          dbc_nxt = dbc + 1'b1;
        end
      end

      ST_EMIT: begin
        state_nxt = ST_RELEASE;
        dbc_nxt   = '0;
      end

      ST_RELEASE: begin
        // Any low row, including other keys in this column, restarts the count.
        if (rs != 4'b1111) begin
          dbc_nxt = '0;
        end else if (dbc == DBC_LAST) begin
          state_nxt    = ST_SCAN;
          col_idx_nxt  = col_idx + 2'd1;
          scan_cnt_nxt = '0;
          dbc_nxt      = '0;
        end else begin
          dbc_nxt = dbc + 1'b1;
        end
      end

      default: begin
        state_nxt = ST_SCAN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  assign col       = ~(4'b0001 << col_idx);
  assign key_code  = key_code_q;
  assign key_valid = (state == ST_EMIT);
  assign key_held  = (state != ST_SCAN);

endmodule

// File: tb/tb_calc_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_calc_keypad_scan
//
// Directed bench for calc_keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=8. A keypad
// model pulls row[r] low when column c is driven and key (r,c) is closed. A
// negedge monitor records every strobe (code, cycle, cycles since key_held
// rose). It also tracks strobe width and any key_code change outside a strobe.
// -----------------------------------------------------------------------------
module tb_calc_keypad_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] key_down;  // key_down[r][c] = key closed

  calc_keypad_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) row[r] = ~|(key_down[r] & ~col);
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] code;
    int         cyc;
    int         lat;
  } ev_t;

  ev_t        evq[$];
  int         cyc         = 0;
  int         held_rise   = 0;
  int         held_cycles = 0;
  int         width_err   = 0;
  int         code_err    = 0;
  logic       prev_held   = 1'b0;
  logic       prev_valid  = 1'b0;
  logic [3:0] prev_code   = 4'd0;

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (rst_n) begin
      if (key_held && !prev_held) held_rise = cyc;
      if (key_valid) begin
        e.code = key_code;
        e.cyc  = cyc;
        e.lat  = cyc - held_rise;
        evq.push_back(e);
        if (prev_valid) width_err++;
      end
      if (key_code != prev_code && !key_valid) code_err++;
      if (key_held) held_cycles++;
    end
    prev_held  = key_held;
    prev_valid = key_valid;
    prev_code  = key_code;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] col_drive(input int n);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << n);
  endfunction

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int seq_r   [5] = '{0, 0, 2, 0, 3};
  int seq_c   [5] = '{1, 2, 2, 3, 2};
  int seq_code[5] = '{1, 2, 10, 3, 14};

  initial begin
    int base;
    int snap;
    int waited;
    logic saw_col3;

    rst_n    = 1'b0;
    key_down = '0;

    // Reset values, then free-running scan with no keys
    repeat (3) @(negedge clk);
    check("rst_col",       col,       4'b1110);
    check("rst_key_code",  key_code,  4'd0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held",  key_held,  1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("idle_col_%0d", i), col, col_drive((i / 4) % 4));
      @(negedge clk);
    end
    check("idle_no_events", evq.size(), 0);
    check("idle_key_code",  key_code,   4'd0);

    // Clean press of (2,1), held 100 clocks
    base = evq.size();
    key_down[2][1] = 1'b1;
    repeat (100) @(negedge clk);
    check("clean_count",    evq.size() - base, 1);
    if (evq.size() > base) begin
      check("clean_code",    evq[base].code, 4'd9);
      check("clean_latency", evq[base].lat,  8);
    end
    check("clean_col_frozen", col,      4'b1101);
    check("clean_held",       key_held, 1'b1);
    check("clean_key_code",   key_code, 4'd9);
    key_down[2][1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9)  check("clean_rel_frozen", col, 4'b1101);
      if (k == 10) check("clean_rel_advance", col, 4'b1011);
    end
    repeat (5) @(negedge clk);
    check("clean_no_extra", evq.size() - base, 1);

    // Bouncy press and bouncy release of (0,3)
    base = evq.size();
    for (int i = 0; i < 20; i++) begin
      key_down[0][3] = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    key_down[0][3] = 1'b1;
    repeat (60) @(negedge clk);
    check("bounce_count", evq.size() - base, 1);
    if (evq.size() > base) begin
      check("bounce_code",    evq[base].code, 4'd3);
      check("bounce_latency", evq[base].lat,  8);
    end
    for (int i = 0; i < 20; i++) begin
      key_down[0][3] = ((i / 3) % 2 == 1);
      @(negedge clk);
    end
    key_down[0][3] = 1'b0;
    repeat (30) @(negedge clk);
    check("bounce_release_count", evq.size() - base, 1);
    check("bounce_release_idle",  key_held, 1'b0);

    // Ghost: (0,0) and (1,0) together
    base     = evq.size();
    snap     = held_cycles;
    saw_col3 = 1'b0;
    key_down[0][0] = 1'b1;
    key_down[1][0] = 1'b1;
    repeat (64) begin
      @(negedge clk);
      if (col == 4'b0111) saw_col3 = 1'b1;
    end
    check("ghost_no_event", evq.size() - base,   0);
    check("ghost_no_held",  held_cycles - snap,  0);
    check("ghost_scanning", saw_col3,            1'b1);
    key_down = '0;
    repeat (10) @(negedge clk);

    // Sequence 1, 2, +, 3, =
    base = evq.size();
    for (int i = 0; i < 5; i++) begin
      key_down[seq_r[i]][seq_c[i]] = 1'b1;
      repeat (40) @(negedge clk);
      key_down[seq_r[i]][seq_c[i]] = 1'b0;
      repeat (30) @(negedge clk);
    end
    check("seq_count", evq.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < evq.size()) begin
        check($sformatf("seq_code_%0d", i), evq[base + i].code, seq_code[i]);
        if (i > 0)
          check($sformatf("seq_spacing_%0d", i),
                (evq[base + i].cyc - evq[base + i - 1].cyc) >= 18, 1'b1);
      end
    end

    // Reset during debounce of (1,1)
    base   = evq.size();
    waited = 0;
    key_down[1][1] = 1'b1;
    while (!key_held && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("rstdb_reached_debounce", key_held, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstdb_col",       col,       4'b1110);
    check("rstdb_key_held",  key_held,  1'b0);
    check("rstdb_key_valid", key_valid, 1'b0);
    check("rstdb_key_code",  key_code,  4'd0);
    check("rstdb_no_event",  evq.size() - base, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rstdb_redetect_count", evq.size() - base, 1);
    if (evq.size() > base) check("rstdb_redetect_code", evq[base].code, 4'd5);
    key_down[1][1] = 1'b0;
    repeat (20) @(negedge clk);

    check("strobe_width",    width_err, 0);
    check("code_stable",     code_err,  0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
